// File: rtl/arb_pkg.sv
// Shared types and helpers for the preemptive arbiter: FSM encoding,
// owner-index width derivation and a saturating increment.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int iw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Operands are widened to 32 bits by the caller; max_v is the all-ones value of the real width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Lowest-set-bit finder: returns the index of the lowest set bit of vec_i
// and whether any bit was set.
module prio_pick
    import arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = iw_of(N)
) (
    input  logic [N-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec_i[i] && !valid_o) begin
                idx_o   = IW'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/preempt_arbiter.sv
// Fixed-priority arbiter for one shared resource with selective preemption,
// suspend/resume of preempted owners, optional hold timeout and event counters.
module preempt_arbiter
    import arb_pkg::*;
#(
    parameter int             N            = 3,
    parameter logic [N-1:0]   PREEMPT_MASK = N'(1),
    parameter int             TIMEOUT      = 0,
    parameter int             CNT_W        = 8,
    parameter int             IW           = iw_of(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      done,
    output logic [N-1:0]      grant,
    output logic [IW-1:0]     accmodule,
    output logic              busy,
    output logic [1:0]        mstate,
    output logic [N-1:0]      suspended,
    output logic [CNT_W-1:0]  nb_interrupts,
    output logic [CNT_W-1:0]  nb_timeouts
);

    localparam int          HCW      = iw_of(TIMEOUT + 2);
    localparam logic [31:0] CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0] HOLD_MAX = 32'((64'd1 << HCW) - 64'd1);

    state_t            state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic              busy_q, busy_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [N-1:0]      susp_q, susp_d;
    logic [HCW-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0]  nint_q, nint_d;
    logic [CNT_W-1:0]  nto_q, nto_d;

    logic [N-1:0]      own_oh;
    logic [N-1:0]      req_masked;
    logic [IW-1:0]     susp_idx, req_idx, pick_idx, pre_idx;
    logic              susp_v, req_v, pick_v, pre_v;
    logic              done_hit, to_hit;

    always_comb begin
        own_oh = '0;
        for (int unsigned i = 0; i < N; i++) begin
            own_oh[i] = busy_q && (32'(owner_q) == i);
        end
    end

    // While owned, the current owner is excluded so a release always hands off or idles.
    assign req_masked = req & ~own_oh;

    prio_pick #(.N(N), .IW(IW)) u_pick_susp (
        .vec_i   (susp_q),
        .idx_o   (susp_idx),
        .valid_o (susp_v)
    );

    prio_pick #(.N(N), .IW(IW)) u_pick_req (
        .vec_i   (req_masked),
        .idx_o   (req_idx),
        .valid_o (req_v)
    );

    assign pick_v   = susp_v | req_v;
    assign pick_idx = susp_v ? susp_idx : req_idx;
    assign done_hit = busy_q && ((done & own_oh) != '0);
    assign to_hit   = (TIMEOUT != 0) && busy_q && (32'(hold_q) == 32'(TIMEOUT));

    always_comb begin
        pre_v   = 1'b0;
        pre_idx = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (busy_q && req[j] && PREEMPT_MASK[j] && (j < 32'(owner_q)) && !pre_v) begin
                pre_v   = 1'b1;
                pre_idx = IW'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        susp_d  = susp_q;
        hold_d  = hold_q;
        nint_d  = nint_q;
        nto_d   = nto_q;

        case (state_q)
            IDLE: begin
                if (pick_v) begin
                    state_d = FIRST;
                    owner_d = pick_idx;
                    busy_d  = 1'b1;
                    hold_d  = HCW'(1);
                    for (int unsigned i = 0; i < N; i++) begin
                        if (32'(pick_idx) == i) susp_d[i] = 1'b0;
                    end
                end
            end
            FIRST, HOLD: begin
                if (done_hit || to_hit) begin
                    if (to_hit && !done_hit) begin
                        nto_d = CNT_W'(sat_inc(32'(nto_q), CNT_MAX));
                    end
                    if (pick_v) begin
                        state_d = FIRST;
                        owner_d = pick_idx;
                        hold_d  = HCW'(1);
                        for (int unsigned i = 0; i < N; i++) begin
                            if (32'(pick_idx) == i) susp_d[i] = 1'b0;
                        end
                    end else begin
                        state_d = IDLE;
                        owner_d = '0;
                        busy_d  = 1'b0;
                        hold_d  = '0;
                    end
                end else if (pre_v) begin
                    state_d = FIRST;
                    owner_d = pre_idx;
                    hold_d  = HCW'(1);
                    nint_d  = CNT_W'(sat_inc(32'(nint_q), CNT_MAX));
                    for (int unsigned i = 0; i < N; i++) begin
                        if (32'(owner_q) == i) susp_d[i] = 1'b1;
                        if (32'(pre_idx) == i) susp_d[i] = 1'b0;
                    end
                end else begin
                    state_d = HOLD;
                    hold_d  = HCW'(sat_inc(32'(hold_q), HOLD_MAX));
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        endcase

        grant_d = '0;
        for (int unsigned i = 0; i < N; i++) begin
            grant_d[i] = busy_d && (32'(owner_d) == i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            busy_q  <= 1'b0;
            grant_q <= '0;
            susp_q  <= '0;
            hold_q  <= '0;
            nint_q  <= '0;
            nto_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
            susp_q  <= susp_d;
            hold_q  <= hold_d;
            nint_q  <= nint_d;
            nto_q   <= nto_d;
        end
    end

    assign grant         = grant_q;
    assign accmodule     = owner_q;
    assign busy          = busy_q;
    assign mstate        = state_q;
    assign suspended     = susp_q;
    assign nb_interrupts = nint_q;
    assign nb_timeouts   = nto_q;

endmodule

// File: tb/tb_preempt_arbiter.sv
// Scoreboard bench for preempt_arbiter (N=3, PREEMPT_MASK=001, TIMEOUT=4):
// stimulus queues hand-computed expectations, a negedge monitor compares them.
module tb_preempt_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req, done;
    logic [2:0] grant, suspended;
    logic [1:0] accmodule, mstate;
    logic       busy;
    logic [7:0] nb_interrupts, nb_timeouts;

    typedef struct {
        string      name;
        int         due;
        logic [2:0] g;
        logic [1:0] a;
        logic       b;
        logic [1:0] st;
        logic [2:0] su;
        logic [7:0] ni;
        logic [7:0] nt;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   applied = 0;
    int   errors  = 0;

    preempt_arbiter #(
        .N            (3),
        .PREEMPT_MASK (3'b001),
        .TIMEOUT      (4),
        .CNT_W        (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .done          (done),
        .grant         (grant),
        .accmodule     (accmodule),
        .busy          (busy),
        .mstate        (mstate),
        .suspended     (suspended),
        .nb_interrupts (nb_interrupts),
        .nb_timeouts   (nb_timeouts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input logic [2:0] r, input logic [2:0] d);
        @(posedge clk);
        #1;
        req  = r;
        done = d;
    endtask

    task automatic expect_now(input string name, input logic [2:0] g, input logic [1:0] a,
                              input logic b, input logic [1:0] st, input logic [2:0] su,
                              input logic [7:0] ni, input logic [7:0] nt);
        exp_t e;
        e.name = name; e.due = cyc; e.g = g; e.a = a; e.b = b;
        e.st = st; e.su = su; e.ni = ni; e.nt = nt;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                applied++;
                if (grant !== e.g || accmodule !== e.a || busy !== e.b || mstate !== e.st ||
                    suspended !== e.su || nb_interrupts !== e.ni || nb_timeouts !== e.nt) begin
                    errors++;
                    $display("FAIL %s: got g=%b a=%0d b=%b st=%0d su=%b ni=%0d nt=%0d, want g=%b a=%0d b=%b st=%0d su=%b ni=%0d nt=%0d",
                             e.name, grant, accmodule, busy, mstate, suspended, nb_interrupts, nb_timeouts,
                             e.g, e.a, e.b, e.st, e.su, e.ni, e.nt);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", applied);
        $fatal(1, "time limit");
    end

    initial begin : stim
        reset = 1'b0;
        req   = 3'b111;
        done  = 3'b000;

        // Reset with all requests held
        drive(3'b111, 3'b000);
        drive(3'b111, 3'b000);
        expect_now("reset_low", 3'b000, 0, 0, 0, 3'b000, 0, 0);
        reset = 1'b1;
        drive(3'b111, 3'b000);
        expect_now("reset_first_grant", 3'b001, 0, 1, 1, 3'b000, 0, 0);
        drive(3'b000, 3'b001);
        expect_now("reset_owner0_hold", 3'b001, 0, 1, 2, 3'b000, 0, 0);
        drive(3'b000, 3'b000);
        expect_now("reset_owner0_release", 3'b000, 0, 0, 0, 3'b000, 0, 0);

        // Basic grant and back-to-back handoff
        drive(3'b110, 3'b000);
        drive(3'b110, 3'b000);
        expect_now("basic_grant1", 3'b010, 1, 1, 1, 3'b000, 0, 0);
        drive(3'b110, 3'b010);
        expect_now("basic_hold1", 3'b010, 1, 1, 2, 3'b000, 0, 0);
        drive(3'b100, 3'b000);
        expect_now("basic_handoff2", 3'b100, 2, 1, 1, 3'b000, 0, 0);
        drive(3'b000, 3'b100);
        expect_now("basic_hold2", 3'b100, 2, 1, 2, 3'b000, 0, 0);
        drive(3'b000, 3'b000);
        expect_now("basic_idle", 3'b000, 0, 0, 0, 3'b000, 0, 0);

        // Preempt owner 2 by channel 0, then resume
        drive(3'b100, 3'b000);
        drive(3'b100, 3'b000);
        drive(3'b001, 3'b000);
        expect_now("pre_owner2_hold", 3'b100, 2, 1, 2, 3'b000, 0, 0);
        drive(3'b000, 3'b000);
        expect_now("pre_preempted", 3'b001, 0, 1, 1, 3'b100, 1, 0);
        drive(3'b000, 3'b001);
        expect_now("pre_owner0_hold", 3'b001, 0, 1, 2, 3'b100, 1, 0);
        drive(3'b000, 3'b000);
        expect_now("pre_resume2", 3'b100, 2, 1, 1, 3'b000, 1, 0);
        drive(3'b000, 3'b100);
        drive(3'b000, 3'b000);
        expect_now("pre_idle", 3'b000, 0, 0, 0, 3'b000, 1, 0);

        // done[owner] and preempting req together: release wins, no interrupt
        drive(3'b010, 3'b000);
        drive(3'b010, 3'b000);
        drive(3'b001, 3'b010);
        drive(3'b000, 3'b000);
        expect_now("sim_release_wins", 3'b001, 0, 1, 1, 3'b000, 1, 0);
        drive(3'b000, 3'b001);
        drive(3'b000, 3'b000);
        expect_now("sim_idle", 3'b000, 0, 0, 0, 3'b000, 1, 0);

        // Channel 1 cannot preempt owner 2
        drive(3'b100, 3'b000);
        drive(3'b110, 3'b000);
        drive(3'b110, 3'b000);
        expect_now("nopre_hold_a", 3'b100, 2, 1, 2, 3'b000, 1, 0);
        drive(3'b010, 3'b100);
        expect_now("nopre_hold_b", 3'b100, 2, 1, 2, 3'b000, 1, 0);
        drive(3'b000, 3'b000);
        expect_now("nopre_handoff1", 3'b010, 1, 1, 1, 3'b000, 1, 0);
        drive(3'b000, 3'b010);
        drive(3'b000, 3'b000);
        expect_now("nopre_idle", 3'b000, 0, 0, 0, 3'b000, 1, 0);

        // Timeout after exactly 4 owned cycles
        drive(3'b100, 3'b000);
        drive(3'b000, 3'b000);
        expect_now("to_grant", 3'b100, 2, 1, 1, 3'b000, 1, 0);
        drive(3'b000, 3'b000);
        drive(3'b000, 3'b000);
        drive(3'b000, 3'b000);
        expect_now("to_fourth_cycle", 3'b100, 2, 1, 2, 3'b000, 1, 0);
        drive(3'b000, 3'b000);
        expect_now("to_released", 3'b000, 0, 0, 0, 3'b000, 1, 1);

        // Saturation of the timeout counter
        for (int i = 0; i < 299; i++) begin
            drive(3'b100, 3'b000);
            drive(3'b000, 3'b000);
            repeat (4) drive(3'b000, 3'b000);
            if (i == 0)   expect_now("to_count2",   3'b000, 0, 0, 0, 3'b000, 1, 8'd2);
            if (i == 252) expect_now("to_count254", 3'b000, 0, 0, 0, 3'b000, 1, 8'd254);
        end
        expect_now("to_saturated", 3'b000, 0, 0, 0, 3'b000, 1, 8'd255);

        // Asynchronous reset while owner 1 holds
        drive(3'b010, 3'b000);
        drive(3'b000, 3'b000);
        drive(3'b000, 3'b000);
        expect_now("async_pre_hold", 3'b010, 1, 1, 2, 3'b000, 1, 8'd255);
        drive(3'b000, 3'b000);
        #2;
        reset = 1'b0;
        expect_now("async_reset_drop", 3'b000, 0, 0, 0, 3'b000, 0, 0);
        drive(3'b000, 3'b000);
        reset = 1'b1;
        drive(3'b000, 3'b000);
        drive(3'b000, 3'b000);

        applied++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule
